// File: rtl/i2cmb_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// i2cmb_xfer_sequencer
//
// Transaction-level front end for the I2CMB Wishbone slave. One request
// (bus, slave address, direction, length) is expanded into the register
// sequence SET_BUS, START, ADDR, N data bytes, STOP. After every command the
// sequencer waits for completion, reads CMDR and decodes DON/NAK/AL/ERR.
// One transaction is in flight at a time; this block is the only wb master.
//
// Parameters
//   NUM_BUSES       number of I2C buses behind the core (req_bus must be below)
//   TIMEOUT_CYCLES  completion wait limit in clk_i cycles, 0 = no limit
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*                   request handshake and fields (held until req_ready)
//   wdata_valid/ready/wdata write byte stream; wdata_ready pulses on consume
//   rdata_valid/rdata       read byte stream; one pulse per received byte
//   done/done_status        end-of-transaction pulse: 00 OK, 01 NAK,
//                           10 arbitration lost, 11 error/timeout/bad bus
//   cyc_o stb_o we_o adr_o dat_o dat_i ack_i   Wishbone master port
//   irq_i                   I2CMB interrupt (command complete)
//
// Configuration macro
//   I2CMB_SEQ_POLL_EN  when defined, irq_i is ignored, the core is enabled
//                      with interrupts off and completion is found by
//                      re-reading CMDR until any of bits 7:4 is set.
// -----------------------------------------------------------------------------
module i2cmb_xfer_sequencer #(
  parameter int unsigned NUM_BUSES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_bus,
  input  logic [6:0] req_addr,
  input  logic       req_rnw,
  input  logic [7:0] req_len,
  input  logic       wdata_valid,
  output logic       wdata_ready,
  input  logic [7:0] wdata,
  output logic       rdata_valid,
  output logic [7:0] rdata,
  output logic       done,
  output logic [1:0] done_status,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       irq_i
);

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_RD_ACK  = 8'h02;
  localparam logic [7:0] CMD_RD_NAK  = 8'h03;
  localparam logic [7:0] CMD_START   = 8'h04;
  localparam logic [7:0] CMD_STOP    = 8'h05;
  localparam logic [7:0] CMD_SET_BUS = 8'h06;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAK = 2'b01;
  localparam logic [1:0] ST_AL  = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

`ifdef I2CMB_SEQ_POLL_EN
  localparam logic [7:0] CSR_INIT = 8'h80;
  logic unused_irq;
  assign unused_irq = irq_i;
`else
  localparam logic [7:0] CSR_INIT = 8'hC0;
`endif

  typedef enum logic [3:0] {
    S_EN_CORE, S_IDLE, S_SET_DPR, S_SET_CMD, S_START, S_ADDR_DPR, S_ADDR_CMD,
    S_DATA_W, S_DATA_W_CMD, S_DATA_R, S_RD_DPR, S_STOP, S_WAIT, S_DONE
  } state_t;

  state_t      state_q, state_d, ret_q, ret_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bus_q;
  logic [6:0]  addr_q;
  logic        rnw_q;
  logic        cyc_q, we_q;
  logic [1:0]  adr_q;
  logic [7:0]  dat_q;
  logic        rdv_q, rdv_d;
  logic [7:0]  rdata_q, rdata_d;

  // Per-state wb access request; the shared logic below launches it when
  // the bus is idle and drops the strobes on ack.
  logic        acc_go, acc_we, acc_abort, acked, ld_req;
  logic [1:0]  acc_adr;
  logic [7:0]  acc_dat;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    status_d    = status_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    rdv_d       = 1'b0;
    rdata_d     = rdata_q;
    acc_go      = 1'b0;
    acc_we      = 1'b1;
    acc_adr     = ADR_CMDR;
    acc_dat     = 8'h00;
    acc_abort   = 1'b0;
    ld_req      = 1'b0;
    wdata_ready = 1'b0;
    acked       = cyc_q & ack_i;

    case (state_q)
      S_EN_CORE: begin
        acc_go  = 1'b1;
        acc_adr = ADR_CSR;
        acc_dat = CSR_INIT;
        if (acked) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          ld_req = 1'b1;
          if (32'(req_bus) >= NUM_BUSES) begin
            status_d = ST_ERR;
            state_d  = S_DONE;
          end else begin
            status_d = ST_OK;
            state_d  = S_SET_DPR;
          end
        end
      end
      S_SET_DPR: begin
        acc_go  = 1'b1;
        acc_adr = ADR_DPR;
        acc_dat = {4'h0, bus_q};
        if (acked) state_d = S_SET_CMD;
      end
      S_SET_CMD: begin
        acc_go  = 1'b1;
        acc_dat = CMD_SET_BUS;
        if (acked) begin state_d = S_WAIT; ret_d = S_START; end
      end
      S_START: begin
        acc_go  = 1'b1;
        acc_dat = CMD_START;
        if (acked) begin state_d = S_WAIT; ret_d = S_ADDR_DPR; end
      end
      S_ADDR_DPR: begin
        acc_go  = 1'b1;
        acc_adr = ADR_DPR;
        acc_dat = {addr_q, rnw_q};
        if (acked) state_d = S_ADDR_CMD;
      end
      S_ADDR_CMD: begin
        acc_go  = 1'b1;
        acc_dat = CMD_WRITE;
        if (acked) begin
          state_d = S_WAIT;
          ret_d   = (cnt_q == 8'd0) ? S_STOP : (rnw_q ? S_DATA_R : S_DATA_W);
        end
      end
      S_DATA_W: begin
        // Bus stays idle until a byte is offered; the byte is consumed in
        // the same cycle its DPR write is launched.
        acc_go      = wdata_valid;
        acc_adr     = ADR_DPR;
        acc_dat     = wdata;
        wdata_ready = ~cyc_q & wdata_valid;
        if (acked) state_d = S_DATA_W_CMD;
      end
      S_DATA_W_CMD: begin
        acc_go  = 1'b1;
        acc_dat = CMD_WRITE;
        if (acked) begin
          state_d = S_WAIT;
          cnt_d   = cnt_q - 8'd1;
          ret_d   = (cnt_q == 8'd1) ? S_STOP : S_DATA_W;
        end
      end
      S_DATA_R: begin
        // The last byte is NAKed so the slave releases SDA before STOP.
        acc_go  = 1'b1;
        acc_dat = (cnt_q == 8'd1) ? CMD_RD_NAK : CMD_RD_ACK;
        if (acked) begin state_d = S_WAIT; ret_d = S_RD_DPR; end
      end
      S_RD_DPR: begin
        acc_go  = 1'b1;
        acc_we  = 1'b0;
        acc_adr = ADR_DPR;
        if (acked) begin
          rdata_d = dat_i;
          rdv_d   = 1'b1;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? S_STOP : S_DATA_R;
        end
      end
      S_STOP: begin
        acc_go  = 1'b1;
        acc_dat = CMD_STOP;
        if (acked) begin state_d = S_WAIT; ret_d = S_DONE; end
      end
      S_WAIT: begin
        acc_we  = 1'b0;
        acc_adr = ADR_CMDR;
`ifdef I2CMB_SEQ_POLL_EN
        acc_go  = 1'b1;
`else
        acc_go  = irq_i;
`endif
        tmo_d   = tmo_q + 32'd1;
        if (acked && dat_i[4]) begin
          status_d = ST_ERR;
          state_d  = S_DONE;
        end else if (acked && dat_i[5]) begin
          status_d = ST_AL;
          state_d  = S_DONE;
        end else if (acked && dat_i[6]) begin
          // A NAK reported for STOP itself does not override the result.
          if (ret_q == S_DONE) begin
            state_d = S_DONE;
          end else begin
            status_d = ST_NAK;
            state_d  = S_STOP;
          end
        end else if (acked && dat_i[7]) begin
          state_d = ret_q;
        end else if (TIMEOUT_CYCLES != 0 && tmo_q >= TIMEOUT_CYCLES - 1) begin
          status_d  = ST_ERR;
          state_d   = S_DONE;
          acc_abort = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_EN_CORE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_EN_CORE;
      ret_q    <= S_IDLE;
      status_q <= ST_OK;
      tmo_q    <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 2'd0;
      dat_q    <= 8'h00;
      rdv_q    <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      rdv_q    <= rdv_d;
      rdata_q  <= rdata_d;
      if (acked || acc_abort) begin
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
        adr_q <= 2'd0;
        dat_q <= 8'h00;
      end else if (!cyc_q && acc_go) begin
        cyc_q <= 1'b1;
        we_q  <= acc_we;
        adr_q <= acc_adr;
        dat_q <= acc_we ? acc_dat : 8'h00;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ld_req) begin
      bus_q  <= req_bus;
      addr_q <= req_addr;
      rnw_q  <= req_rnw;
      cnt_q  <= req_len;
    end else begin
      cnt_q  <= cnt_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign done_status = done ? status_q : 2'b00;
  assign rdata_valid = rdv_q;
  assign rdata       = rdata_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;

endmodule

// File: tb/tb_i2cmb_xfer_sequencer.sv
module tb_i2cmb_xfer_sequencer;

`ifdef I2CMB_SEQ_POLL_EN
  localparam logic [7:0] CSR_EXP = 8'h80;
`else
  localparam logic [7:0] CSR_EXP = 8'hC0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_bus = '0;
  logic [6:0] req_addr = '0;
  logic       req_rnw = 1'b0;
  logic [7:0] req_len = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic [7:0] wdata = '0;
  logic       rdata_valid;
  logic [7:0] rdata;
  logic       done;
  logic [1:0] done_status;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i = '0;
  logic       ack_i = 1'b0;
  logic       irq_i = 1'b0;

  i2cmb_xfer_sequencer #(.NUM_BUSES(12), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_bus(req_bus),
    .req_addr(req_addr), .req_rnw(req_rnw), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .done(done), .done_status(done_status),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  always #5 clk = ~clk;

  int cycle_n = 0;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0, done_cnt = 0, rd_cnt = 0, wrdy_cnt = 0;
  int last_cmd_cyc = 0, done_cyc = 0;
  logic hold_ack = 1'b0;
  logic pending = 1'b0;
  logic take = 1'b0;
  logic [7:0] pend_val = '0;

  logic [10:0] exp_acc_q[$];
  logic [7:0]  resp_q[$];
  logic [7:0]  dpr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  wq[$];
  logic [1:0]  exp_st_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_w(input logic [1:0] a, input logic [7:0] d);
    exp_acc_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_r(input logic [1:0] a);
    exp_acc_q.push_back({1'b0, a, 8'h00});
  endtask

  // Command write followed by the completion read of CMDR.
  task automatic exp_cmd(input logic [7:0] c);
    exp_w(2'd2, c);
    exp_r(2'd2);
  endtask

  task automatic log_acc(input logic w, input logic [1:0] a, input logic [7:0] d);
    logic [31:0] e;
    e = 'x;
    acc_cnt++;
    if (exp_acc_q.size() != 0) e = {21'h0, exp_acc_q.pop_front()};
    check_eq("wb_access", {21'h0, w, a, d}, e);
  endtask

  // Wishbone slave model, write-data source and output monitors.
  initial begin
    logic r;
    logic [31:0] e;
    logic [7:0] c;
    forever begin
      @(negedge clk);
      r = wdata_ready;
      if (rst) begin
        ack_i = 1'b0; dat_i = '0; irq_i = 1'b0; pending = 1'b0; take = 1'b0;
      end else begin
        wrdy_cnt += int'(r);
        if (take && wq.size() != 0) void'(wq.pop_front());
        take = r;
        if (done) begin
          done_cnt++;
          done_cyc = cycle_n;
          e = 'x;
          if (exp_st_q.size() != 0) e = {30'h0, exp_st_q.pop_front()};
          check_eq("done_status", {30'h0, done_status}, e);
        end
        if (rdata_valid) begin
          rd_cnt++;
          e = 'x;
          if (exp_rd_q.size() != 0) e = {24'h0, exp_rd_q.pop_front()};
          check_eq("rdata", {24'h0, rdata}, e);
        end
        if (ack_i) begin
          ack_i = 1'b0;
          dat_i = '0;
        end else if (cyc_o && stb_o && !hold_ack) begin
          ack_i = 1'b1;
          dat_i = '0;
          if (we_o) begin
            log_acc(1'b1, adr_o, dat_o);
            if (adr_o == 2'd2) begin
              last_cmd_cyc = cycle_n + 1;
              c = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h80;
              if (c != 8'h00) begin
                pending = 1'b1; pend_val = c; irq_i = 1'b1;
              end
            end
          end else if (adr_o == 2'd2) begin
            if (pending) begin
              dat_i = pend_val; pending = 1'b0; irq_i = 1'b0;
              log_acc(1'b0, adr_o, 8'h00);
            end else begin
`ifndef I2CMB_SEQ_POLL_EN
              log_acc(1'b0, adr_o, 8'h00);
`endif
            end
          end else begin
            if (adr_o == 2'd1) dat_i = (dpr_q.size() != 0) ? dpr_q.pop_front() : 8'hEE;
            log_acc(1'b0, adr_o, 8'h00);
          end
        end
      end
      wdata_valid = (wq.size() != 0);
      wdata = (wq.size() != 0) ? wq[0] : 8'h00;
    end
  end

  task automatic issue_req(input logic [3:0] bus, input logic [6:0] addr,
                           input logic rnw, input logic [7:0] len);
    int n;
    req_bus = bus; req_addr = addr; req_rnw = rnw; req_len = len;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_xfer(input logic [3:0] bus, input logic [6:0] addr, input logic rnw,
                          input logic [7:0] len, input logic [1:0] st, input string tag);
    int d0, n;
    d0 = done_cnt;
    exp_st_q.push_back(st);
    issue_req(bus, addr, rnw, len);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
    check_eq({tag, "_done_cnt"}, done_cnt - d0, 1);
    repeat (2) @(negedge clk);
    check_eq({tag, "_wb_left"}, exp_acc_q.size(), 0);
    resp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int a0, w0, r0, d0, n;
    repeat (3) @(negedge clk);
    check_eq("rst_cyc", cyc_o, 0);
    check_eq("rst_stb", stb_o, 0);
    check_eq("rst_we", we_o, 0);
    check_eq("rst_adr", adr_o, 0);
    check_eq("rst_dat", dat_o, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_done", {done, done_status}, 0);
    check_eq("rst_rdata", {rdata_valid, rdata}, 0);
    check_eq("rst_wrdy", wdata_ready, 0);

    exp_w(2'd0, CSR_EXP);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("init_acc_cnt", acc_cnt, 1);
    check_eq("init_ready", req_ready, 1);
    check_eq("init_left", exp_acc_q.size(), 0);

    // Write bus 2, addr 0x22, two bytes.
    exp_w(2'd1, 8'h02); exp_cmd(8'h06); exp_cmd(8'h04);
    exp_w(2'd1, 8'h44); exp_cmd(8'h01);
    exp_w(2'd1, 8'h5A); exp_cmd(8'h01);
    exp_w(2'd1, 8'hA5); exp_cmd(8'h01);
    exp_cmd(8'h05);
    w0 = wrdy_cnt;
    wq.push_back(8'h5A); wq.push_back(8'hA5);
    run_xfer(4'd2, 7'h22, 1'b0, 8'd2, 2'b00, "wr");
    check_eq("wr_wrdy", wrdy_cnt - w0, 2);

    // Read bus 0, addr 0x22, three bytes.
    exp_w(2'd1, 8'h00); exp_cmd(8'h06); exp_cmd(8'h04);
    exp_w(2'd1, 8'h45); exp_cmd(8'h01);
    exp_cmd(8'h02); exp_r(2'd1);
    exp_cmd(8'h02); exp_r(2'd1);
    exp_cmd(8'h03); exp_r(2'd1);
    exp_cmd(8'h05);
    dpr_q = '{8'h11, 8'h22, 8'h33};
    exp_rd_q = '{8'h11, 8'h22, 8'h33};
    r0 = rd_cnt;
    run_xfer(4'd0, 7'h22, 1'b1, 8'd3, 2'b00, "rd");
    check_eq("rd_bytes", rd_cnt - r0, 3);

    // Address NAK on a write: STOP issued, no byte consumed.
    exp_w(2'd1, 8'h01); exp_cmd(8'h06); exp_cmd(8'h04);
    exp_w(2'd1, 8'hA0); exp_cmd(8'h01); exp_cmd(8'h05);
    resp_q = '{8'h80, 8'h80, 8'hC0, 8'h80};
    wq.push_back(8'h99);
    w0 = wrdy_cnt;
    run_xfer(4'd1, 7'h50, 1'b0, 8'd2, 2'b01, "nak");
    check_eq("nak_wrdy", wrdy_cnt - w0, 0);
    wq.delete();
    repeat (2) @(negedge clk);

    // Arbitration lost on START: no STOP.
    exp_w(2'd1, 8'h03); exp_cmd(8'h06); exp_cmd(8'h04);
    resp_q = '{8'h80, 8'h20};
    run_xfer(4'd3, 7'h10, 1'b0, 8'd1, 2'b10, "al");

    // Status priority on the address phase: ERR wins, then AL over NAK.
    exp_w(2'd1, 8'h04); exp_cmd(8'h06); exp_cmd(8'h04);
    exp_w(2'd1, 8'h23); exp_cmd(8'h01);
    resp_q = '{8'h80, 8'h80, 8'hF0};
    run_xfer(4'd4, 7'h11, 1'b1, 8'd1, 2'b11, "err");
    exp_w(2'd1, 8'h04); exp_cmd(8'h06); exp_cmd(8'h04);
    exp_w(2'd1, 8'h23); exp_cmd(8'h01);
    resp_q = '{8'h80, 8'h80, 8'hE0};
    run_xfer(4'd4, 7'h11, 1'b1, 8'd1, 2'b10, "alnak");

    // Bus ids out of range: status 11 and no wb traffic.
    a0 = acc_cnt;
    run_xfer(4'd12, 7'h10, 1'b0, 8'd1, 2'b11, "bus12");
    run_xfer(4'd15, 7'h10, 1'b1, 8'd4, 2'b11, "bus15");
    check_eq("badbus_acc", acc_cnt - a0, 0);

    // Address-only probes: OK, NAK reported, NAK on STOP ignored.
    for (int k = 0; k < 3; k++) begin
      exp_w(2'd1, 8'h05); exp_cmd(8'h06); exp_cmd(8'h04);
      exp_w(2'd1, 8'h60); exp_cmd(8'h01); exp_cmd(8'h05);
      if (k == 1) resp_q = '{8'h80, 8'h80, 8'hC0, 8'h80};
      if (k == 2) resp_q = '{8'h80, 8'h80, 8'h80, 8'hC0};
      run_xfer(4'd5, 7'h30, 1'b0, 8'd0, (k == 1) ? 2'b01 : 2'b00, "probe");
    end

    // SET_BUS never completes: timeout, no STOP.
    exp_w(2'd1, 8'h06); exp_w(2'd2, 8'h06);
    resp_q = '{8'h00};
    run_xfer(4'd6, 7'h40, 1'b0, 8'd1, 2'b11, "tmo");
    check_eq("tmo_window", ((done_cyc - last_cmd_cyc) >= 95) && ((done_cyc - last_cmd_cyc) <= 100), 1);

    // Reset while a DATA_W DPR write is stalled on the bus.
    exp_w(2'd1, 8'h07); exp_cmd(8'h06); exp_cmd(8'h04);
    exp_w(2'd1, 8'h24); exp_cmd(8'h01);
    issue_req(4'd7, 7'h12, 1'b0, 8'd2);
    n = 0;
    while (exp_acc_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    check_eq("mid_addr_done", exp_acc_q.size(), 0);
    hold_ack = 1'b1;
    wq.push_back(8'h77);
    n = 0;
    while (!cyc_o && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check_eq("mid_cyc", {cyc_o, we_o, adr_o, dat_o}, {1'b1, 1'b1, 2'd1, 8'h77});
    d0 = done_cnt;
    a0 = acc_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1 check_eq("rst_drop_cyc", cyc_o, 0);
    hold_ack = 1'b0;
    wq.delete(); exp_acc_q.delete(); resp_q.delete();
    exp_w(2'd0, CSR_EXP);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rerun_en_core", acc_cnt - a0, 1);
    check_eq("rerun_left", exp_acc_q.size(), 0);
    check_eq("rerun_ready", req_ready, 1);
    check_eq("rst_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
